if_fetch: RTL and testbench

- Instruction fetch unit at the front of the pipeline.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. Tolerates variable memory latency.
- Buffers returned instructions with their PCs and presents them, one per cycle, to the if_id pipeline register that feeds the decode stage.
- Handles downstream stalls and PC redirects from branch/jump resolution, discarding wrong-path responses still in flight.

---
 rtl/if_fetch_pkg.sv | 31 +++
 rtl/if_fetch_if.sv | 36 +++
 rtl/if_fetch_fifo.sv | 90 +++++++++
 rtl/if_fetch.sv | 113 +++++++++++
 tb/tb_if_fetch.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module  : if_fetch_pkg
// Brief   : Shared types and constants for the instruction fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

   localparam logic        c_rst_enable      = 1'b1;
   localparam logic [31:0] c_zero_word       = 32'h0000_0000;
   localparam logic [31:0] c_nop_inst        = 32'h0000_0013;
   localparam logic [31:0] c_inst_word_bytes = 32'd4;
   localparam int          c_inst_addr_w     = 32;
   localparam int          c_inst_w          = 32;

   typedef logic [c_inst_addr_w-1:0] inst_addr_t;
   typedef logic [c_inst_w-1:0]      inst_t;

   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } fetch_entry_t;

   function automatic inst_addr_t word_align(input inst_addr_t addr);
      return {addr[c_inst_addr_w-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_if.sv
// ============================================================================
// Module  : if_fetch_if
// Brief   : Instruction-memory request/grant/response bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_if
   import if_fetch_pkg::*;
();

   logic       imem_req_o;
   inst_addr_t imem_addr_o;
   logic       imem_gnt_i;
   logic       imem_rvalid_i;
   inst_t      imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous {pc, inst} FIFO with a registered head entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import if_fetch_pkg::*;
#(
   parameter int           DEPTH      = 2,
   parameter fetch_entry_t RESET_HEAD = '0,
   localparam int          AW         = $clog2(DEPTH),
   localparam int          CW         = $clog2(DEPTH) + 1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          push,
   input  wire logic          pop,
   input  wire logic          flush,
   input  wire fetch_entry_t  push_data,
   output      fetch_entry_t  head,
   output      logic          empty,
   output      logic          full,
   output      logic [CW-1:0] count
);

   fetch_entry_t  r_mem [DEPTH];
   fetch_entry_t  r_head;
   fetch_entry_t  w_head_nxt;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;

   // The head register is refreshed from the slot that becomes the head;
   // if that slot is being written this cycle the incoming data bypasses it.
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(pop);
      w_count_nxt  = r_count + CW'(push) - CW'(pop);
      w_head_nxt   = r_head;
      if (w_count_nxt != '0) begin
         if (push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = push_data;
         end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((rst != c_rst_enable) && !flush && push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == c_rst_enable) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= RESET_HEAD;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_count  <= w_count_nxt;
         r_head   <= w_head_nxt;
      end
   end

   assign head  = r_head;
   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == CW'(DEPTH));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module  : if_fetch
// Brief   : Fetch unit: PC, credit-limited imem requests, instruction buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        stall_i,
   input  wire logic        redirect_i,
   input  wire logic [31:0] redirect_pc_i,
   if_fetch_if.master       imem,
   output      logic [31:0] pc_o,
   output      logic [31:0] inst_o,
   output      logic        inst_valid_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = CW + 1;

   inst_addr_t    r_fetch_pc;
   inst_addr_t    r_resp_pc;
   inst_addr_t    w_redirect_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard_cnt;
   logic [CW-1:0] w_count;
   logic [IW-1:0] w_inflight;
   logic          w_pop;
   logic          w_push;
   logic          w_req;
   logic          w_grant;
   logic          w_drop;
   logic          w_empty;
   logic          w_full;
   fetch_entry_t  w_head;
   fetch_entry_t  w_push_data;

   // Requests are issued only while every in-flight word is guaranteed a
   // buffer slot, so the FIFO can never overflow regardless of memory latency.
   always_comb begin
      w_pop         = inst_valid_o && !stall_i && !redirect_i;
      w_inflight    = IW'(r_outstanding) + IW'(w_count) - IW'(w_pop);
      w_req         = (rst != c_rst_enable) && !redirect_i
                      && (w_inflight < IW'(FIFO_DEPTH));
      w_grant       = w_req && imem.imem_gnt_i;
      w_drop        = redirect_i || (r_discard_cnt != '0);
      w_push        = imem.imem_rvalid_i && !w_drop;
      w_push_data   = '{pc: r_resp_pc, inst: imem.imem_rdata_i};
      w_redirect_pc = word_align(redirect_pc_i);
   end

   always_ff @(posedge clk) begin
      if (rst == c_rst_enable) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard_cnt <= '0;
      end else if (redirect_i) begin
         // Everything still in flight belongs to the abandoned path.
         r_fetch_pc    <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
         r_outstanding <= r_outstanding - CW'(imem.imem_rvalid_i);
         r_discard_cnt <= r_outstanding - CW'(imem.imem_rvalid_i);
      end else begin
         if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + c_inst_word_bytes;
         end
         r_outstanding <= r_outstanding + CW'(w_grant) - CW'(imem.imem_rvalid_i);
         if (imem.imem_rvalid_i) begin
            if (r_discard_cnt != '0) begin
               r_discard_cnt <= r_discard_cnt - CW'(1);
            end else begin
               r_resp_pc <= r_resp_pc + c_inst_word_bytes;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .RESET_HEAD ({RESET_PC, c_nop_inst})
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .pop       (w_pop),
      .flush     (redirect_i),
      .push_data (w_push_data),
      .head      (w_head),
      .empty     (w_empty),
      .full      (w_full),
      .count     (w_count)
   );

   assign imem.imem_req_o  = w_req;
   assign imem.imem_addr_o = r_fetch_pc;
   assign inst_valid_o     = !w_empty;
   assign pc_o             = w_head.pc;
   assign inst_o           = w_empty ? c_nop_inst : w_head.inst;

   a_credit_holds: assert property (@(posedge clk) disable iff (rst)
      !(w_push && w_full && !w_pop));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module  : tb_if_fetch
// Brief   : Directed self-checking bench for if_fetch with a latency-model imem.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;
   import if_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   if_fetch_if bus ();

   if_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem          (bus),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic        stall;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   mreq_t q[$];
   vec_t  tv[12];
   int    checks    = 0;
   int    failures  = 0;
   int    cyc       = 0;
   int    lat       = 1;
   int    gnt_delay = 0;
   int    wait_cnt  = 0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
   endfunction

   function automatic logic [31:0] exp_inst(input logic v, input logic [31:0] pc);
      return v ? data_of(pc) : c_nop_inst;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // Applies this cycle's inputs at the negedge; gnt is decided once req settles.
   task automatic drive(input logic s, input logic r, input logic [31:0] rpc);
      stall_i       = s;
      redirect_i    = r;
      redirect_pc_i = rpc;
      if (q.size() > 0 && q[0].due <= cyc) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = data_of(q[0].addr);
      end else begin
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = '0;
      end
      bus.imem_gnt_i = 1'b0;
      #1;
      bus.imem_gnt_i = bus.imem_req_o && (wait_cnt >= gnt_delay);
      #1;
   endtask

   task automatic advance();
      logic        fire;
      logic        resp;
      logic        held;
      logic [31:0] a;
      fire = bus.imem_req_o && bus.imem_gnt_i;
      held = bus.imem_req_o && !bus.imem_gnt_i;
      resp = bus.imem_rvalid_i;
      a    = bus.imem_addr_o;
      @(posedge clk);
      if (rst) begin
         q.delete();
         wait_cnt = 0;
      end else begin
         if (resp) q.delete(0);
         if (fire) q.push_back('{addr: a, due: cyc + lat});
         wait_cnt = held ? wait_cnt + 1 : 0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk({tag, "_req"},   32'(bus.imem_req_o), 32'h0);
      chk({tag, "_valid"}, 32'(inst_valid_o),   32'h0);
      chk({tag, "_pc"},    pc_o,                32'h0);
      chk({tag, "_inst"},  inst_o,              c_nop_inst);
      advance();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] exp_addr;
      logic [31:0] prev_addr;
      logic        prev_held;
      logic        found;
      int          delivered;
      int          n10;

      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;

      //            stall  req   addr          valid pc
      tv[0]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tv[1]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
      tv[2]  = '{1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
      tv[3]  = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[4]  = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[5]  = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[6]  = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[7]  = '{1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[8]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
      tv[9]  = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
      tv[10] = '{1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
      tv[11] = '{1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};

      @(negedge clk);

      // Streaming and stall with a single-cycle memory.
      lat = 1; gnt_delay = 0;
      do_reset("rst_a");
      for (int i = 0; i < 12; i++) begin
         drive(tv[i].stall, 1'b0, 32'h0);
         chk("t_req",   32'(bus.imem_req_o), 32'(tv[i].exp_req));
         chk("t_addr",  bus.imem_addr_o,     tv[i].exp_addr);
         chk("t_valid", 32'(inst_valid_o),   32'(tv[i].exp_valid));
         chk("t_pc",    pc_o,                tv[i].exp_pc);
         chk("t_inst",  inst_o,              exp_inst(tv[i].exp_valid, tv[i].exp_pc));
         advance();
      end

      // Slow memory: 3-cycle response, grant after 2 cycles of waiting.
      lat = 3; gnt_delay = 2;
      do_reset("rst_b");
      exp_pc = 0; exp_addr = 0; prev_addr = 0; prev_held = 0; delivered = 0; n10 = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         if (prev_held) begin
            chk("b_hold_req",  32'(bus.imem_req_o), 32'h1);
            chk("b_hold_addr", bus.imem_addr_o,     prev_addr);
         end
         chk("b_out_cap", 32'(q.size() <= 2), 32'h1);
         if (bus.imem_req_o && bus.imem_gnt_i) begin
            chk("b_req_order", bus.imem_addr_o, exp_addr);
            exp_addr += 4;
         end
         if (bus.imem_req_o && !bus.imem_gnt_i && bus.imem_addr_o == 32'h10) n10++;
         if (inst_valid_o) begin
            chk("b_pc",   pc_o,   exp_pc);
            chk("b_inst", inst_o, data_of(exp_pc));
            exp_pc += 4;
            delivered++;
         end
         prev_held = bus.imem_req_o && !bus.imem_gnt_i;
         prev_addr = bus.imem_addr_o;
         advance();
      end
      chk("b_delivered", 32'(delivered >= 8), 32'h1);
      chk("b_wait_0x10", 32'(n10 >= 2),       32'h1);

      // Redirect with two requests in flight.
      lat = 3; gnt_delay = 0;
      do_reset("rst_c");
      drive(1'b0, 1'b0, 32'h0);
      chk("c_addr0", bus.imem_addr_o, 32'h0);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("c_addr1", bus.imem_addr_o, 32'h4);
      advance();
      drive(1'b0, 1'b1, 32'h0000_1002);
      chk("c_redir_req", 32'(bus.imem_req_o), 32'h0);
      chk("c_inflight",  32'(q.size()),       32'h2);
      advance();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         if (i == 0) chk("c_new_addr", bus.imem_addr_o, 32'h0000_1000);
         if (inst_valid_o) begin
            chk("c_first_pc",   pc_o,   32'h0000_1000);
            chk("c_first_inst", inst_o, data_of(32'h0000_1000));
            found = 1'b1;
         end
         advance();
      end
      if (!found) chk("c_first_valid_timeout", 32'h0, 32'h1);

      // Redirect coinciding with a response and a stall.
      lat = 1; gnt_delay = 0;
      do_reset("rst_d");
      drive(1'b0, 1'b0, 32'h0); advance();
      drive(1'b0, 1'b0, 32'h0); advance();
      drive(1'b1, 1'b1, 32'h0000_2000);
      chk("d_pre_valid", 32'(inst_valid_o), 32'h1);
      chk("d_pre_pc",    pc_o,              32'h0);
      chk("d_req",       32'(bus.imem_req_o), 32'h0);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("d_flush_valid", 32'(inst_valid_o),   32'h0);
      chk("d_flush_inst",  inst_o,              c_nop_inst);
      chk("d_hold_pc",     pc_o,                32'h0);
      chk("d_new_req",     32'(bus.imem_req_o), 32'h1);
      chk("d_new_addr",    bus.imem_addr_o,     32'h0000_2000);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("d_addr2",  bus.imem_addr_o,   32'h0000_2004);
      chk("d_valid2", 32'(inst_valid_o), 32'h0);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("d_pc3",   pc_o,   32'h0000_2000);
      chk("d_inst3", inst_o, data_of(32'h0000_2000));
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("d_pc4", pc_o, 32'h0000_2004);
      advance();

      // Address wrap, then reset in the middle of a burst.
      do_reset("rst_e");
      drive(1'b0, 1'b1, 32'hFFFF_FFFE); advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("e_addr_top", bus.imem_addr_o, 32'hFFFF_FFFC);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("e_addr_wrap", bus.imem_addr_o,     32'h0);
      chk("e_req_wrap",  32'(bus.imem_req_o), 32'h1);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("e_pc_top", pc_o, 32'hFFFF_FFFC);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("e_pc_wrap",   pc_o,   32'h0);
      chk("e_inst_wrap", inst_o, data_of(32'h0));
      advance();
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      chk("e_rst_req", 32'(bus.imem_req_o), 32'h0);
      chk("e_pre_pc",  pc_o,                32'h4);
      advance();
      drive(1'b0, 1'b0, 32'h0);
      chk("e_rst_valid", 32'(inst_valid_o), 32'h0);
      chk("e_rst_pc",    pc_o,              32'h0);
      chk("e_rst_inst",  inst_o,            c_nop_inst);
      advance();
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0);
      chk("e_post_req",  32'(bus.imem_req_o), 32'h1);
      chk("e_post_addr", bus.imem_addr_o,     32'h0);
      advance();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
